// File: rtl/pipe_pkg.sv
// Shared types and constants for the fetch front end of the RV64I-Zba pipeline.
//   NOP_INSTR  : addi x0,x0,0 - shown on Instr_D whenever the queue head is empty
//   fq_entry_t : one fetch queue slot {pc, instr}
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/instr_mem.sv
// Instruction ROM, combinational read.
//   clk, we, waddr, wdata : write port for an image loader (tied off in the fetch stage)
//   addr                  : word index
//   instr                 : rom[addr]
module instr_mem #(
  parameter int IMEM_DEPTH = 256
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] waddr,
  input  logic [31:0]                   wdata,
  input  logic [$clog2(IMEM_DEPTH)-1:0] addr,
  output logic [31:0]                   instr
);

  logic [31:0] rom [IMEM_DEPTH];

  always_ff @(posedge clk)
    if (we) rom[waddr] <= wdata;

  assign instr = rom[addr];

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage: PC generation, instruction ROM and an FQ_DEPTH-entry fetch queue
// feeding decode.
//   clk, rst     : clock, synchronous active-high reset
//   PCTarget_E   : redirect target from execute (low two bits dropped)
//   PCSrc_E      : redirect request; flushes the queue
//   Stall_D      : decode cannot accept the head this cycle
//   PC_D, PCPlus4_D, Instr_D, Valid_D : queue head (PC_D = 0 and Instr_D = NOP when empty)
// Optional macro FETCH_PERF_CNT_EN adds FetchCnt_F (pushes) and FlushCnt_F
// (valid entries discarded by redirects, saturating).
module fetch_queue_stage
  import pipe_pkg::*;
#(
  parameter int          XLEN       = 64,
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          IMEM_DEPTH = 256,
  parameter int          FQ_DEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PCTarget_E,
  input  logic            PCSrc_E,
  input  logic            Stall_D,
  output logic [XLEN-1:0] PC_D,
  output logic [XLEN-1:0] PCPlus4_D,
  output logic [31:0]     Instr_D,
  output logic            Valid_D
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0]     FetchCnt_F,
  output logic [63:0]     FlushCnt_F
`endif
);

  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int PW = $clog2(FQ_DEPTH);

  logic [XLEN-1:0] pc_f;
  logic [31:0]     rom_instr;
  fq_entry_t       q [FQ_DEPTH];
  fq_entry_t       head;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [PW:0]     count;
  logic            push, pop;

  instr_mem #(.IMEM_DEPTH(IMEM_DEPTH)) imem (
    .clk   (clk),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .addr  (pc_f[IW+1:2]),
    .instr (rom_instr)
  );

  assign head    = q[rd_ptr];
  assign Valid_D = (count != '0);
  assign pop     = Valid_D & ~Stall_D;
  // A full queue may still accept when the head leaves in the same cycle.
  assign push    = ~PCSrc_E & ((count < (PW+1)'(FQ_DEPTH)) | pop);

  assign PC_D      = Valid_D ? head.pc[XLEN-1:0] : '0;
  assign PCPlus4_D = PC_D + XLEN'(4);
  assign Instr_D   = Valid_D ? head.instr : NOP_INSTR;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f   <= RESET_PC[XLEN-1:0];
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (PCSrc_E) begin
      pc_f   <= {PCTarget_E[XLEN-1:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_f   <= pc_f + XLEN'(4);
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  // Payload needs no reset: slots are only read while count says they are live.
  always_ff @(posedge clk)
    if (!rst && push) q[wr_ptr] <= '{pc: 64'(pc_f), instr: rom_instr};

`ifdef FETCH_PERF_CNT_EN
  logic [64:0] flush_sum;
  assign flush_sum = {1'b0, FlushCnt_F} + 65'(count);

  always_ff @(posedge clk) begin
    if (rst) begin
      FetchCnt_F <= '0;
      FlushCnt_F <= '0;
    end else begin
      if (push) FetchCnt_F <= FetchCnt_F + 64'd1;
      if (PCSrc_E) FlushCnt_F <= flush_sum[64] ? '1 : flush_sum[63:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage: stimulus queues the expected stream of
// instructions consumed by decode; a negedge monitor checks each consumed head.
module tb_fetch_queue_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst, PCSrc_E, Stall_D;
  logic [63:0] PCTarget_E, PC_D, PCPlus4_D;
  logic [31:0] Instr_D;
  logic        Valid_D;
`ifdef FETCH_PERF_CNT_EN
  logic [63:0] FetchCnt_F, FlushCnt_F;
`endif

  fetch_queue_stage dut (
    .clk(clk), .rst(rst), .PCTarget_E(PCTarget_E), .PCSrc_E(PCSrc_E), .Stall_D(Stall_D),
    .PC_D(PC_D), .PCPlus4_D(PCPlus4_D), .Instr_D(Instr_D), .Valid_D(Valid_D)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCnt_F(FetchCnt_F), .FlushCnt_F(FlushCnt_F)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] img [256];
  fq_entry_t   exp_q [$];
  int          n_cmp = 0, n_err = 0;

  function automatic logic [31:0] exp_instr(input logic [63:0] pc);
    return img[pc[9:2]];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Head must equal start_pc now; run n unstalled cycles, expecting sequential consumption.
  task automatic run_free(input logic [63:0] start_pc, input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{pc: start_pc + 64'(4*k), instr: exp_instr(start_pc + 64'(4*k))});
      step();
    end
  endtask

  // Monitor: a head is consumed when valid, not stalled and not flushed.
  always @(negedge clk) begin
    if (!rst && Valid_D && !Stall_D && !PCSrc_E) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pop: got pc %h with empty scoreboard", PC_D);
      end else begin
        fq_entry_t e;
        e = exp_q.pop_front();
        chk("pop_pc", PC_D, e.pc);
        chk("pop_instr", 64'(Instr_D), 64'(e.instr));
        chk("pop_pcplus4", PCPlus4_D, e.pc + 64'd4);
      end
    end
  end

  task automatic chk_empty(input string name);
    chk({name, "_valid"}, 64'(Valid_D), 64'd0);
    chk({name, "_pc"}, PC_D, 64'd0);
    chk({name, "_pcplus4"}, PCPlus4_D, 64'd4);
    chk({name, "_instr"}, 64'(Instr_D), 64'(NOP_INSTR));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) img[i] = 32'hA5A5_0000 | 32'(i);
    img[0]   = 32'h0010_0093;
    img[1]   = 32'h0020_0113;
    img[2]   = 32'h0030_0193;
    img[20]  = 32'h6464_6464;
    img[255] = 32'hDEAD_BEEF;
    for (int i = 0; i < 256; i++) dut.imem.rom[i] = img[i];

    rst = 1'b1; PCSrc_E = 1'b0; Stall_D = 1'b0; PCTarget_E = '0;
    step(); step();
    chk_empty("reset");
    rst = 1'b0;
    step();
    // First instruction one cycle after release.
    chk("first_valid", 64'(Valid_D), 64'd1);
    run_free(64'h0, 1);

    // Stall with head at 4: queue fills, head held.
    Stall_D = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stall_hold_pc", PC_D, 64'h4);
    end
    Stall_D = 1'b0;
    run_free(64'h4, 4);

    // Redirect to 0x50.
    PCSrc_E = 1'b1; PCTarget_E = 64'd80;
    step();
    PCSrc_E = 1'b0;
    chk("redir_bubble", 64'(Valid_D), 64'd0);
    step();
    run_free(64'h50, 2);

    // Full queue under stall, then misaligned redirect while still stalled.
    Stall_D = 1'b1;
    step(); step();
    chk("full_hold_pc", PC_D, 64'h58);
    PCSrc_E = 1'b1; PCTarget_E = 64'h3FE;
    step();
    PCSrc_E = 1'b0;
    chk("stall_redir_bubble", 64'(Valid_D), 64'd0);
    step();
    chk("stall_redir_pc", PC_D, 64'h3FC);
    chk("stall_redir_instr", 64'(Instr_D), 64'hDEAD_BEEF);
    step();
    Stall_D = 1'b0;
    // 0x400 wraps to ROM index 0.
    run_free(64'h3FC, 3);
`ifdef FETCH_PERF_CNT_EN
    chk("flush_cnt", FlushCnt_F, 64'd4);
`endif

    // Reset while full.
    Stall_D = 1'b1;
    step(); step();
    rst = 1'b1;
    step();
    chk_empty("midreset");
`ifdef FETCH_PERF_CNT_EN
    chk("reset_fetch_cnt", FetchCnt_F, 64'd0);
    chk("reset_flush_cnt", FlushCnt_F, 64'd0);
`endif
    rst = 1'b0; Stall_D = 1'b0;
    step();
    chk("post_reset_pc", PC_D, 64'h0);
    run_free(64'h0, 3);

    Stall_D = 1'b1;
    step(); step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
